// File: rtl/fp_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// fp_pipe_skid_reg
//
// Elastic pipeline register used at the FPU stage boundaries (mul->add,
// add->norm). It carries an opaque payload of W bits between two stages using a
// valid/ready handshake.
//
// SKID=1 : two entries (main + skid). in_ready is taken straight from a flop,
//          so downstream back-pressure never reaches upstream combinationally.
// SKID=0 : a single entry. in_ready = !out_valid | out_ready (combinational).
//
// Besides the datapath there is a synchronous flush that cancels everything held,
// and a saturating counter of stall cycles (out_valid=1 while out_ready=0).
//
// Ports
//   clk        in   rising-edge clock
//   clrn       in   asynchronous active-low reset
//   flush      in   synchronous cancel of all held entries
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept (registered when SKID=1)
//   in_data    in   upstream payload, W bits
//   out_valid  out  downstream payload valid
//   out_ready  in   downstream accepts
//   out_data   out  payload to next stage, W bits
//   occupancy  out  entries held (0..2, at most 1 when SKID=0)
//   stall_cnt  out  saturating count of stall cycles, CNTW bits
//   stall_clr  in   synchronous clear of stall_cnt
// -----------------------------------------------------------------------------
module fp_pipe_skid_reg #(
    parameter int W    = 126,
    parameter int SKID = 1,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [1:0]      occupancy,
    output logic [CNTW-1:0] stall_cnt,
    input  logic            stall_clr
);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        logic [CNTW-1:0] one;
        one = {{(CNTW-1){1'b0}}, 1'b1};
        if (&v) begin
            return v;
        end
        return v + one;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic            main_v_q,    main_v_d;
    logic            skid_v_q,    skid_v_d;
    logic [W-1:0]    main_data_q, main_data_d;
    logic [W-1:0]    skid_data_q, skid_data_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic            accept;
    logic            emit;
    logic            stalled;

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    // In skid mode the skid slot is the only thing that can block the input,
    // so ready is just its (registered) empty flag.
    assign in_ready  = (SKID != 0) ? !skid_v_q : (!main_v_q || out_ready);
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;

    assign accept  = in_valid && in_ready;
    assign emit    = main_v_q && out_ready;
    assign stalled = main_v_q && !out_ready;

    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign stall_cnt = stall_cnt_q;

    // ---------------------------------------------------------------------
    // Next-state for entries
    // ---------------------------------------------------------------------
    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Cancel: only the valids clear, data registers keep stale content.
            // Anything accepted this cycle is dropped on purpose.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (SKID != 0) begin
            unique case ({main_v_q, skid_v_q})
                2'b00: begin
                    if (accept) begin
                        main_data_d = in_data;
                        main_v_d    = 1'b1;
                    end
                end
                2'b10: begin
                    if (emit) begin
                        if (accept) begin
                            // Zero-bubble replacement of the departing entry.
                            main_data_d = in_data;
                        end else begin
                            main_v_d = 1'b0;
                        end
                    end else if (accept) begin
                        // Downstream stalled: park the new word in the skid slot.
                        skid_data_d = in_data;
                        skid_v_d    = 1'b1;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so accept cannot happen.
                    if (emit) begin
                        main_data_d = skid_data_q;
                        skid_v_d    = 1'b0;
                    end
                end
                default: begin
                    // Skid-only is unreachable; recover by promoting it to main
                    // so order is preserved and nothing is lost.
                    main_data_d = skid_data_q;
                    main_v_d    = 1'b1;
                    skid_v_d    = 1'b0;
                end
            endcase
        end else begin
            // Single-entry mode: accept and emit may coincide, accept wins.
            skid_v_d = 1'b0;
            if (accept) begin
                main_data_d = in_data;
                main_v_d    = 1'b1;
            end else if (emit) begin
                main_v_d = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stall counter (independent of flush; clear wins over increment)
    // ---------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (stalled) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_fp_pipe_skid_reg
//
// Two instances share clk/clrn: u_a is a skid build (SKID=1, CNTW=4), u_b is a
// single-entry build (SKID=0). A queue model per instance predicts the outputs
// and a compare loop checks them on every falling edge; directed steps add
// literal expectations.
// -----------------------------------------------------------------------------
module tb_fp_pipe_skid_reg;

    localparam int W = 16;

    logic clk = 1'b0;
    logic clrn;

    always #5 clk = ~clk;

    // Instance A (skid)
    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall_clr;
    logic [W-1:0]  a_in_data, a_out_data;
    logic [1:0]    a_occupancy;
    logic [3:0]    a_stall_cnt;

    // Instance B (single entry)
    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall_clr;
    logic [W-1:0]  b_in_data, b_out_data;
    logic [1:0]    b_occupancy;
    logic [15:0]   b_stall_cnt;

    fp_pipe_skid_reg #(.W(W), .SKID(1), .CNTW(4)) u_a (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occupancy),
        .stall_cnt (a_stall_cnt),
        .stall_clr (a_stall_clr)
    );

    fp_pipe_skid_reg #(.W(W), .SKID(0), .CNTW(16)) u_b (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occupancy),
        .stall_cnt (b_stall_cnt),
        .stall_clr (b_stall_clr)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------------------------------------------------------------
    // Behavioural model: a bounded FIFO per instance plus a stall counter.
    // ---------------------------------------------------------------------
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int unsigned  cnt_a = 0;
    int unsigned  cnt_b = 0;

    initial begin
        bit acc, emt;
        forever begin
            @(posedge clk or negedge clrn);
            if (!clrn) begin
                qa.delete();
                qb.delete();
                cnt_a = 0;
                cnt_b = 0;
            end else begin
                // A: capacity 2, ready whenever not full
                emt = (qa.size() > 0) && a_out_ready;
                acc = a_in_valid && (qa.size() < 2);
                if (a_stall_clr) cnt_a = 0;
                else if (qa.size() > 0 && !a_out_ready && cnt_a < 15) cnt_a++;
                if (a_flush) qa.delete();
                else begin
                    if (emt) void'(qa.pop_front());
                    if (acc) qa.push_back(a_in_data);
                end
                // B: capacity 1, ready when empty or draining
                emt = (qb.size() > 0) && b_out_ready;
                acc = b_in_valid && ((qb.size() == 0) || b_out_ready);
                if (b_stall_clr) cnt_b = 0;
                else if (qb.size() > 0 && !b_out_ready && cnt_b < 65535) cnt_b++;
                if (b_flush) qb.delete();
                else begin
                    if (emt) void'(qb.pop_front());
                    if (acc) qb.push_back(b_in_data);
                end
            end
        end
    end

    // Compare loop on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("a_out_valid", a_out_valid, qa.size() > 0);
            chk("a_occupancy", a_occupancy, qa.size());
            chk("a_in_ready",  a_in_ready,  qa.size() < 2);
            chk("a_stall_cnt", a_stall_cnt, cnt_a);
            if (qa.size() > 0) chk("a_out_data", a_out_data, qa[0]);
            chk("b_out_valid", b_out_valid, qb.size() > 0);
            chk("b_occupancy", b_occupancy, qb.size());
            chk("b_in_ready",  b_in_ready,  (qb.size() == 0) || b_out_ready);
            chk("b_stall_cnt", b_stall_cnt, cnt_b);
            if (qb.size() > 0) chk("b_out_data", b_out_data, qb[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Directed stimulus
    // ---------------------------------------------------------------------
    initial begin
        clrn = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_stall_clr = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_stall_clr = 0;
        #2 clrn = 1'b0;
        #1;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_data",  a_out_data,  0);
        chk("rst_a_occ",       a_occupancy, 0);
        chk("rst_a_in_ready",  a_in_ready,  1);
        chk("rst_a_stall",     a_stall_cnt, 0);
        chk("rst_b_in_ready",  b_in_ready,  1);
        chk("rst_b_out_valid", b_out_valid, 0);
        repeat (2) cyc();
        clrn = 1'b1;

        // Streaming 1..10, one cycle latency each
        a_out_ready = 1;
        for (int k = 1; k <= 10; k++) begin
            a_in_valid = 1;
            a_in_data  = W'(k);
            cyc();
            chk("stream_valid", a_out_valid, 1);
            chk("stream_data",  a_out_data,  k);
            chk("stream_occ",   a_occupancy, 1);
        end
        a_in_valid = 0;
        cyc();
        chk("stream_end_valid", a_out_valid, 0);
        chk("stream_stall",     a_stall_cnt, 0);

        // Back-pressure
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h0011;
        cyc();
        a_in_data = 16'h0022;
        cyc();
        a_in_valid = 0;
        chk("bp_occ",      a_occupancy, 2);
        chk("bp_in_ready", a_in_ready,  0);
        chk("bp_data",     a_out_data,  16'h0011);
        chk("bp_stall1",   a_stall_cnt, 1);
        repeat (2) cyc();
        chk("bp_hold",     a_out_data,  16'h0011);
        chk("bp_stall3",   a_stall_cnt, 3);
        a_out_ready = 1;
        cyc();
        chk("bp_second",   a_out_data,  16'h0022);
        chk("bp_ready_back", a_in_ready, 1);
        chk("bp_stall_keep", a_stall_cnt, 3);
        cyc();
        chk("bp_drained",  a_out_valid, 0);

        // Flush while full
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h0055;
        cyc();
        a_in_data = 16'h0066;
        cyc();
        chk("fl_full", a_occupancy, 2);
        a_in_data = 16'h0033; a_flush = 1;
        cyc();
        a_flush = 0; a_in_valid = 0;
        chk("fl_valid",    a_out_valid, 0);
        chk("fl_occ",      a_occupancy, 0);
        chk("fl_in_ready", a_in_ready,  1);
        chk("fl_stall",    a_stall_cnt, 5);
        a_out_ready = 1;
        repeat (2) cyc();
        chk("fl_no_33", a_out_valid, 0);

        // Flush with an accept into an empty stage discards that word
        a_in_valid = 1; a_in_data = 16'h0077; a_flush = 1;
        cyc();
        a_flush = 0; a_in_valid = 0;
        chk("fl_empty_occ", a_occupancy, 0);

        // Stall counter saturation, then clear
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h0012;
        cyc();
        a_in_valid = 0;
        repeat (20) cyc();
        chk("sat_15", a_stall_cnt, 15);
        a_stall_clr = 1;
        cyc();
        a_stall_clr = 0;
        chk("clr_0", a_stall_cnt, 0);
        cyc();
        chk("after_clr_1", a_stall_cnt, 1);
        a_out_ready = 1;
        cyc();
        chk("sat_drain", a_out_valid, 0);

        // Async reset mid-stream with two entries held
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 16'h0021;
        cyc();
        a_in_data = 16'h0022;
        cyc();
        a_in_valid = 0;
        chk("ar_full", a_occupancy, 2);
        #2 clrn = 1'b0;
        #1;
        chk("ar_valid", a_out_valid, 0);
        chk("ar_occ",   a_occupancy, 0);
        chk("ar_stall", a_stall_cnt, 0);
        chk("ar_data",  a_out_data,  0);
        chk("ar_ready", a_in_ready,  1);
        @(posedge clk);
        #1 clrn = 1'b1;
        a_out_ready = 1; a_in_valid = 1; a_in_data = 16'h0044;
        cyc();
        a_in_valid = 0;
        chk("ar_44_valid", a_out_valid, 1);
        chk("ar_44_data",  a_out_data,  16'h0044);
        cyc();

        // Single-entry build
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 16'h0051;
        cyc();
        b_in_data = 16'h0052;
        chk("b_load",  b_out_data, 16'h0051);
        chk("b_block", b_in_ready, 0);
        cyc();
        chk("b_hold",  b_out_data,  16'h0051);
        chk("b_occ1",  b_occupancy, 1);
        b_out_ready = 1;
        #1 chk("b_comb_up", b_in_ready, 1);
        b_out_ready = 0;
        #1 chk("b_comb_dn", b_in_ready, 0);
        b_out_ready = 1;
        cyc();
        chk("b_swap",     b_out_data,  16'h0052);
        chk("b_swap_occ", b_occupancy, 1);
        b_in_data = 16'h0053;
        cyc();
        chk("b_swap2", b_out_data, 16'h0053);
        b_in_valid = 0;
        cyc();
        chk("b_empty", b_out_valid, 0);
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 16'h0054;
        cyc();
        b_in_data = 16'h0055; b_flush = 1;
        cyc();
        b_flush = 0; b_in_valid = 0;
        chk("b_flush", b_out_valid, 0);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_pipe_skid_reg.md
Name: fp_pipe_skid_reg

Overview:
- Parametrised elastic pipeline register for the pipelined FPU datapath (mul→add, add→norm stage boundaries).
- Carries an arbitrary-width stage payload, such as sum/carry vectors, exponent, rounding mode, and special-case flags.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure never creates a combinational ready path.
- Adds a synchronous flush for pipeline cancel and a saturating stall-cycle counter for performance monitoring.

Parameters:
- W, 126, payload width in bits (the full mul→add stage bundle).
- SKID, 1, 1 = 2-entry skid mode; 0 = single-entry mode where in_ready = !out_valid | out_ready (combinational).
- CNTW, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous cancel of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept (registered when SKID=1).
- in_data  in  W  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_data  out  W  payload to next stage.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNTW  saturating count of cycles with out_valid=1 and out_ready=0.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (clrn=0, async):
  - main_v=0, skid_v=0, out_valid=0, out_data=0, skid data=0.
  - occupancy=0, stall_cnt=0.
  - in_ready=1 (SKID=1) or 1 via the combinational term (SKID=0).
- Handshakes:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - in_data is sampled only on Accept; out_data holds stable while out_valid=1 and out_ready=0.
- out_valid = main_v; out_data = main register. Latency is 1 cycle from Accept into an empty stage; throughput is 1 per cycle.
- SKID=1 next-state rules (in_ready = !skid_v):
  - main empty, Accept → main <= in_data, main_v=1.
  - main full, Emit, skid empty, Accept → main <= in_data (zero bubble).
  - main full, Emit, skid empty, no Accept → main_v=0.
  - main full, no Emit, Accept → skid <= in_data, skid_v=1; in_ready drops next cycle.
  - main full, skid full, Emit → main <= skid, skid_v=0; no Accept is possible because in_ready=0.
  - main full, skid full, no Emit → hold everything.
- SKID=0: a single register; main loads on Accept, clears on Emit without Accept. occupancy never exceeds 1.
- Payload order is strictly FIFO; no entry is ever dropped or duplicated except by flush.
- Flush (priority over Accept and Emit in the same cycle):
  - Next cycle main_v=0, skid_v=0, occupancy=0.
  - The data registers keep their old value; only the valids clear.
  - Input presented in the flush cycle is discarded.
  - The upstream sees Accept that cycle if in_ready=1; that payload is deliberately discarded.
  - in_ready=1 after flush.
- occupancy = main_v + skid_v (registered valids).
- stall_cnt:
  - Increments on each clock with out_valid & !out_ready.
  - Saturates at 2^CNTW-1.
  - stall_clr sets it to 0; stall_clr wins over increment.
  - stall_cnt is unaffected by flush.
- Reset mid-operation: all valids clear immediately (async) and the in-flight payload is lost; normal operation resumes on the first clock edge after clrn rises.
- No X on outputs after reset; out_data may show stale payload while out_valid=0. Consumers must qualify out_data with out_valid.

Test Plan:
- Streaming: out_ready=1 held, in_valid=1 with data 1,2,3,...,10 on consecutive cycles → out_data 1..10 on consecutive cycles, each 1 cycle after its input; occupancy ≤1; stall_cnt=0.
- Back-pressure: send A=0x11, B=0x22 while out_ready=0 → occupancy=2, in_ready=0, out_data=0x11 stable, stall_cnt increments per cycle.
  - Then raise out_ready → 0x11, then 0x22 emerge on consecutive cycles; in_ready returns to 1 one cycle after the skid drains.
- Flush while full: occupancy=2 with in_valid=1, in_data=0x33 and flush=1 → next cycle out_valid=0, occupancy=0, in_ready=1; 0x33 never appears at the output.
- Stall counter: CNTW=4, hold out_valid=1 with out_ready=0 for 20 cycles → stall_cnt saturates at 15.
  - stall_clr=1 together with a stall cycle → stall_cnt=0 next cycle.
- Async reset mid-stream: assert clrn=0 between clock edges with occupancy=2 → out_valid, occupancy, stall_cnt and out_data read 0 immediately.
  - After release, the first accepted payload 0x44 appears 1 cycle later.
- SKID=0 build: out_ready=0 with out_valid=1 → in_ready=0 combinationally.
  - Set out_ready=1 and in_valid=1 in the same cycle → simultaneous Emit and Accept, new payload on the next cycle, occupancy stays 1.
